// File: rtl/expansao_chave_seq.sv
// AES-128/192/256 key schedule: one word per cycle, each group of 4 words leaves as a 128-bit round key over valid/ready.
// Latency: round key k is valid after E(4k+4) from the inicio edge; with EXPANSAO_PIPE_EN each word i>=NK takes 2 cycles.
// Backpressure: word production pauses only while a 4th word would overwrite an unaccepted round key.
module expansao_chave_seq #(
   parameter int NK = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              inicio,
   input  logic [32*NK-1:0]  chave,
   output logic              ocupado,
   output logic              saida_valida,
   input  logic              saida_pronta,
   output logic [127:0]      chave_rodada,
   output logic [3:0]        indice_rodada,
   output logic              ultima
);
   localparam int NR = NK + 6;
   localparam logic [5:0] ULTIMA_PAL = 6'(4*NR + 3);
   localparam logic [5:0] NK6        = 6'(NK);
   localparam logic [2:0] NK_MAX     = 3'(NK - 1);
   localparam logic [3:0] NR4        = 4'(NR);

   generate
      if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_invalido
         $error("expansao_chave_seq: NK must be 4, 6 or 8");
      end
   endgenerate

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] funcaog(input logic [31:0] w, input logic [7:0] rc);
      return subword({w[23:0], w[31:24]}) ^ {rc, 24'h000000};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   typedef enum logic [1:0] {OCIOSO, GERA, ESVAZIA} estado_t;

   estado_t          estado;
   logic [5:0]       i;
   logic [2:0]       modc;
   logic [7:0]       rcon;
   logic [32*NK-1:0] janela;
   logic [95:0]      monta;
   logic [1:0]       cnt4;
   logic [31:0]      w_velho, w_ant, t_comb, t_uso, novo;
   logic             pode, gera_palavra, aceita;

   // Oldest window word sits at the top; the key is loaded there and rotated through for i < NK.
   assign w_velho = janela[32*NK-1 -: 32];
   assign w_ant   = janela[31:0];
   assign aceita  = saida_valida && saida_pronta;
   assign pode    = (estado == GERA) && !(cnt4 == 2'd3 && saida_valida && !saida_pronta);

   always_comb begin
      t_comb = w_ant;
      if (modc == 3'd0)
         t_comb = funcaog(w_ant, rcon);
      else if (NK == 8 && modc == 3'd4)
         t_comb = subword(w_ant);
   end

   assign novo = (i < NK6) ? w_velho : (w_velho ^ t_uso);

`ifdef EXPANSAO_PIPE_EN
   logic        fase;
   logic [31:0] t_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fase  <= 1'b0;
         t_reg <= 32'h0;
      end else if (gera_palavra) begin
         fase <= 1'b0;
      end else if (estado == GERA && i >= NK6 && !fase) begin
         fase  <= 1'b1;
         t_reg <= t_comb;
      end
   end

   assign t_uso        = t_reg;
   assign gera_palavra = pode && (i < NK6 || fase);
`else
   assign t_uso        = t_comb;
   assign gera_palavra = pode;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado        <= OCIOSO;
         i             <= 6'd0;
         modc          <= 3'd0;
         rcon          <= 8'h00;
         janela        <= '0;
         monta         <= 96'h0;
         cnt4          <= 2'd0;
         ocupado       <= 1'b0;
         saida_valida  <= 1'b0;
         chave_rodada  <= 128'h0;
         indice_rodada <= 4'd0;
         ultima        <= 1'b0;
      end else begin
         if (aceita) begin
            saida_valida <= 1'b0;
            ultima       <= 1'b0;
         end
         case (estado)
            OCIOSO: begin
               if (inicio) begin
                  estado  <= GERA;
                  ocupado <= 1'b1;
                  janela  <= chave;
                  i       <= 6'd0;
                  modc    <= 3'd0;
                  rcon    <= 8'h01;
                  cnt4    <= 2'd0;
               end
            end
            GERA: begin
               if (gera_palavra) begin
                  janela <= {janela[32*NK-33:0], novo};
                  i      <= i + 6'd1;
                  modc   <= (modc == NK_MAX) ? 3'd0 : modc + 3'd1;
                  cnt4   <= cnt4 + 2'd1;
                  if (i >= NK6 && modc == 3'd0)
                     rcon <= xtime(rcon);
                  // A completed key overrides any same-edge acceptance of the previous one.
                  if (cnt4 == 2'd3) begin
                     chave_rodada  <= {monta, novo};
                     indice_rodada <= i[5:2];
                     saida_valida  <= 1'b1;
                     ultima        <= (i[5:2] == NR4);
                  end else begin
                     monta <= {monta[63:0], novo};
                  end
                  if (i == ULTIMA_PAL)
                     estado <= ESVAZIA;
               end
            end
            ESVAZIA: begin
               if (aceita) begin
                  estado  <= OCIOSO;
                  ocupado <= 1'b0;
               end
            end
            default: estado <= OCIOSO;
         endcase
      end
   end
endmodule
